// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module   : sequential_divider
//  Purpose  : 8-bit / 4-bit unsigned restoring divider, one quotient bit per
//             clock, MSB first. Three-state FSM: IDLE -> RUN (8 cycles) ->
//             DONE (1 cycle) -> IDLE.
//  Ports    : clk   - clock, all state changes on the rising edge
//             rst   - asynchronous, active-low reset
//             start - request, sampled only in IDLE
//             a     - 8-bit dividend, captured on the accepting edge
//             b     - 4-bit divisor, captured on the accepting edge
//             busy  - high in RUN and DONE
//             done  - one-cycle completion pulse (state == DONE)
//             q     - registered quotient, held until the next completion
//             r     - registered remainder, held until the next completion
//             dz    - divide-by-zero flag (only with DIV_ZERO_FLAG_EN)
//  Config   : define DIV_ZERO_FLAG_EN to add the registered dz output.
//             Divide by zero always yields q = 8'hFF, r = 4'h0.
//  Revision : 1.0  initial release
// ============================================================================
module sequential_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [3:0] r
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic       dz
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] dvd_q,   dvd_d;     // latched dividend
    logic [3:0] dvs_q,   dvs_d;     // latched divisor
    logic [4:0] part_q,  part_d;    // partial remainder
    logic [2:0] cnt_q,   cnt_d;     // index of the quotient bit being produced
    logic [6:0] quo_q,   quo_d;     // quotient bits produced so far
    logic [7:0] q_q,     q_d;
    logic [3:0] r_q,     r_d;

    logic [4:0] w_shift;
    logic       w_ge;
    logic [4:0] w_rem;

    // Shift the next dividend bit into the partial remainder. A set top bit
    // of the old partial remainder means the shifted value is at least 32,
    // which always exceeds the divisor, so it forces a subtract step.
    assign w_shift = {part_q[3:0], dvd_q[cnt_q]};
    assign w_ge    = part_q[4] | (w_shift >= {1'b0, dvs_q});
    assign w_rem   = w_ge ? (w_shift - {1'b0, dvs_q}) : w_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            dvs_q   <= 4'd0;
            part_q  <= 5'd0;
            cnt_q   <= 3'd0;
            quo_q   <= 7'd0;
            q_q     <= 8'd0;
            r_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    dvd_d   = a;
                    dvs_d   = b;
                    part_d  = 5'd0;
                    cnt_d   = 3'd7;
                    quo_d   = 7'd0;
                end
            end

            S_RUN: begin
                part_d = w_rem;
                quo_d  = {quo_q[5:0], w_ge};
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    // With a zero divisor every step subtracts nothing, so the
                    // quotient is already all ones; the remainder is forced.
                    if (dvs_q == 4'd0) begin
                        q_d = 8'hFF;
                        r_d = 4'h0;
                    end else begin
                        q_d = {quo_q, w_ge};
                        r_d = w_rem[3:0];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DIV_ZERO_FLAG_EN
    logic dz_q, dz_d;

    always_comb begin
        dz_d = dz_q;
        if ((state_q == S_RUN) && (cnt_q == 3'd0)) begin
            dz_d = (dvs_q == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign dz = dz_q;
`endif

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign q    = q_q;
    assign r    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequential_divider
//  Purpose  : Self-checking bench for sequential_divider. A behavioural model
//             predicts busy/done/q/r from acceptance time and plain integer
//             division; a compare process checks every cycle, and directed
//             scenarios pin known results and latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sequential_divider;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a     = 8'd0;
    logic [3:0] b     = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [3:0] r;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz;
`endif

    sequential_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz    (dz)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an accepted request is busy for 9 cycles, with the
    // result (plain integer division) appearing in the 9th together with done.
    // ------------------------------------------------------------------
    bit         m_active = 1'b0;
    int         m_phase  = 0;
    logic [7:0] m_q  = 8'd0, m_pq = 8'd0;
    logic [3:0] m_r  = 4'd0, m_pr = 4'd0;
    logic       m_dz = 1'b0, m_pdz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_q      = 8'd0;
            m_r      = 4'd0;
            m_dz     = 1'b0;
        end else if (m_active) begin
            m_phase++;
            if (m_phase == 8) begin
                m_q  = m_pq;
                m_r  = m_pr;
                m_dz = m_pdz;
            end else if (m_phase == 9) begin
                m_active = 1'b0;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_phase  = 0;
            if (b == 4'd0) begin
                m_pq  = 8'hFF;
                m_pr  = 4'd0;
                m_pdz = 1'b1;
            end else begin
                m_pq  = 8'(int'(a) / int'(b));
                m_pr  = 4'(int'(a) % int'(b));
                m_pdz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, m_active});
        chk("cyc_done", {31'd0, done}, {31'd0, (m_active && m_phase == 8)});
        chk("cyc_q", {24'd0, q}, {24'd0, m_q});
        chk("cyc_r", {28'd0, r}, {28'd0, m_r});
`ifdef DIV_ZERO_FLAG_EN
        chk("cyc_dz", {31'd0, dz}, {31'd0, m_dz});
`endif
    end

    // Issue one operation from a negedge; returns the result, the number of
    // negedges until acceptance was visible, and the acceptance-to-done latency.
    task automatic run_op(input logic [7:0] aa, input logic [3:0] bb,
                          output logic [7:0] oq, output logic [3:0] orr,
                          output int acc, output int lat);
        a     = aa;
        b     = bb;
        start = 1'b1;
        acc   = 0;
        do begin
            @(negedge clk);
            acc++;
        end while (!(busy && !done) && acc < 30);
        chk("accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 4'($urandom);
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 8);
        oq  = q;
        orr = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] rq;
        logic [3:0] rr;
        int         acc, lat, ndone;

        // Asynchronous reset with no clock edge involved
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_r", {28'd0, r}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 255 / 7
        run_op(8'd255, 4'd7, rq, rr, acc, lat);
        chk("d255_7_q", {24'd0, rq}, 32'd36);
        chk("d255_7_r", {28'd0, rr}, 32'd3);
        chk("d255_7_acc", acc, 1);

        // Back-to-back: second start raised during DONE, accepted right after
        run_op(8'd105, 4'd7, rq, rr, acc, lat);
        chk("d105_7_q", {24'd0, rq}, 32'd15);
        chk("d105_7_r", {28'd0, rr}, 32'd0);
        run_op(8'd200, 4'd13, rq, rr, acc, lat);
        chk("d200_13_q", {24'd0, rq}, 32'd15);
        chk("d200_13_r", {28'd0, rr}, 32'd5);
        chk("d200_13_acc", acc, 2);

        // Divide by zero
        run_op(8'd8, 4'd0, rq, rr, acc, lat);
        chk("dz_q", {24'd0, rq}, 32'hFF);
        chk("dz_r", {28'd0, rr}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("dz_flag", {31'd0, dz}, 32'd1);
`endif
        run_op(8'd9, 4'd2, rq, rr, acc, lat);
        chk("d9_2_q", {24'd0, rq}, 32'd4);
        chk("d9_2_r", {28'd0, rr}, 32'd1);
`ifdef DIV_ZERO_FLAG_EN
        chk("dz_clear", {31'd0, dz}, 32'd0);
`endif

        // start held high with operands changing every cycle
        repeat (3) @(negedge clk);
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        chk("held_start_dones", ndone, 20);
        repeat (12) @(negedge clk);

        // Reset in the 4th RUN cycle
        a     = 8'd200;
        b     = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'd0);
        chk("abort_r", {28'd0, r}, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(8'd15, 4'd4, rq, rr, acc, lat);
        chk("d15_4_q", {24'd0, rq}, 32'd3);
        chk("d15_4_r", {28'd0, rr}, 32'd3);

        // Exhaustive sweep of all non-zero divisors
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 1; ib < 16; ib++) begin
                run_op(8'(ia), 4'(ib), rq, rr, acc, lat);
                chk("sweep_arith", int'(rq) * ib + int'(rr), ia);
                chk("sweep_r_lt_b", {31'd0, (int'(rr) < ib)}, 32'd1);
            end
        end

        // Random operations with random idle gaps
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(8'($urandom), 4'($urandom_range(0, 15)), rq, rr, acc, lat);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
